// File: rtl/lcd_pkg.sv
// Shared constants and helpers for the LCD write arbiter: FSM state
// encoding, HD44780 DDRAM address command bits and message clamping.
package lcd_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_CHAR = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] LCD_LINE2_OFFSET  = 8'h40;
  localparam int         LCD_LINE_LEN      = 16;

  // Number of characters actually written: the requested length, saturated
  // at one full line, then cut so the message never runs past the line end.
  function automatic logic [4:0] clamp_len(input logic [4:0] len,
                                           input logic [3:0] col,
                                           input int         line_len);
    logic [4:0] sat;
    logic [4:0] room;
    sat  = (len > 5'(line_len)) ? 5'(line_len) : len;
    room = 5'(line_len) - {1'b0, col};
    return (sat < room) ? sat : room;
  endfunction

endpackage

// File: rtl/lcd_write_arbiter_if.sv
// Requester/bus-driver bundle for the LCD write arbiter. The arbiter
// uses the master modport; the environment (requesters plus byte-level
// LCD bus driver) uses the slave modport.
interface lcd_write_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   req_line;
  logic [NUM_REQ*4-1:0] req_col;
  logic [NUM_REQ*5-1:0] req_len;
  logic [NUM_REQ*8-1:0] char_in;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic [3:0]           char_idx;
  logic                 bus_valid;
  logic                 bus_rs;
  logic [7:0]           bus_data;
  logic                 bus_ready;

  modport master (
    input  req, req_line, req_col, req_len, char_in, bus_ready,
    output gnt, done, char_idx, bus_valid, bus_rs, bus_data
  );

  modport slave (
    output req, req_line, req_col, req_len, char_in, bus_ready,
    input  gnt, done, char_idx, bus_valid, bus_rs, bus_data
  );

endinterface

// File: rtl/lcd_write_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester above the last grant,
// wrapping around. The caller registers the result.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [NUM_REQ-1:0] o_winner,
  output logic               o_any_req
);

  assign o_any_req = |i_req;

  // Scan last_grant+1, +2, ... with wrap; the last_grant slot itself is
  // visited last so a lone repeat requester still wins.
  always_comb begin
    int  idx;
    logic found;
    o_winner = '0;
    found    = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(i_last_grant) + k) % NUM_REQ;
      if (!found && i_req[idx]) begin
        o_winner[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Shares one 16x2 character LCD between NUM_REQ message writers. Grants
// one requester at a time (round robin) and streams a set-DDRAM-address
// command followed by the message characters to the byte-level bus driver.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no grant; pick a winner and latch its line/col/length
//   ADDR    | present set-DDRAM-address command beat (rs=0)
//   CHAR    | present character char_idx of the granted requester (rs=1)
//   DONE    | pulse done, remember last grant, drop gnt
module lcd_write_arbiter
  import lcd_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int LINE_LEN = LCD_LINE_LEN
) (
  input logic               clk,
  input logic               reset_n,
  lcd_write_arbiter_if.master lcd_if
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [1:0]         r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_done;
  logic [3:0]         r_char_idx;
  logic               r_line;
  logic [3:0]         r_col;
  logic [4:0]         r_len;
  logic [IDX_W-1:0]   r_gnt_idx;
  logic [IDX_W-1:0]   r_last_grant;

  logic [NUM_REQ-1:0] w_winner;
  logic               w_any_req;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_sel_line;
  logic [3:0]         w_sel_col;
  logic [4:0]         w_sel_len;
  logic [4:0]         w_eff_len;
  logic [7:0]         w_char;
  logic               w_last_char;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_req        (lcd_if.req),
    .i_last_grant (r_last_grant),
    .o_winner     (w_winner),
    .o_any_req    (w_any_req)
  );

  // Binary index of the one-hot winner, used to pick its request fields.
  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner[i]) w_win_idx = IDX_W'(i);
    end
  end

  assign w_sel_line  = lcd_if.req_line[w_win_idx];
  assign w_sel_col   = lcd_if.req_col[4*w_win_idx +: 4];
  assign w_sel_len   = lcd_if.req_len[5*w_win_idx +: 5];
  assign w_eff_len   = clamp_len(w_sel_len, w_sel_col, LINE_LEN);
  assign w_char      = lcd_if.char_in[8*r_gnt_idx +: 8];
  assign w_last_char = ({1'b0, r_char_idx} == (r_len - 5'd1));

  // Main sequencer: arbitration, field latching and beat stepping.
  // A zero-length message skips the bus entirely and goes straight to DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_gnt        <= '0;
      r_done       <= '0;
      r_char_idx   <= '0;
      r_line       <= 1'b0;
      r_col        <= '0;
      r_len        <= '0;
      r_gnt_idx    <= '0;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
    end else begin
      r_done <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_gnt      <= w_winner;
            r_gnt_idx  <= w_win_idx;
            r_line     <= w_sel_line;
            r_col      <= w_sel_col;
            r_len      <= w_eff_len;
            r_char_idx <= '0;
            if (w_eff_len == 5'd0) begin
              r_state <= ST_DONE;
              r_done  <= w_winner;
            end else begin
              r_state <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (lcd_if.bus_ready) begin
            r_char_idx <= '0;
            r_state    <= ST_CHAR;
          end
        end
        ST_CHAR: begin
          if (lcd_if.bus_ready) begin
            if (w_last_char) begin
              r_state <= ST_DONE;
              r_done  <= r_gnt;
            end else begin
              r_char_idx <= r_char_idx + 4'd1;
            end
          end
        end
        ST_DONE: begin
          r_last_grant <= r_gnt_idx;
          r_gnt        <= '0;
          r_char_idx   <= '0;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Beat content is a pure function of the registered state so it cannot
  // move while the driver is stalling us.
  always_comb begin
    lcd_if.bus_valid = 1'b0;
    lcd_if.bus_rs    = 1'b0;
    lcd_if.bus_data  = 8'h00;
    case (r_state)
      ST_ADDR: begin
        lcd_if.bus_valid = 1'b1;
        lcd_if.bus_data  = LCD_CMD_SET_DDRAM
                         | (r_line ? LCD_LINE2_OFFSET : 8'h00)
                         | {4'h0, r_col};
      end
      ST_CHAR: begin
        lcd_if.bus_valid = 1'b1;
        lcd_if.bus_rs    = 1'b1;
        lcd_if.bus_data  = w_char;
      end
      default: ;
    endcase
  end

  assign lcd_if.gnt      = r_gnt;
  assign lcd_if.done     = r_done;
  assign lcd_if.char_idx = r_char_idx;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Randomized bench for lcd_write_arbiter. Expected grant order and byte
// streams come from a message-level model: round-robin search over the
// request vector and a list of beats built from line/col/len/message text.
module tb_lcd_write_arbiter;

  localparam int N = 3;

  logic clk;
  logic reset_n;

  lcd_write_arbiter_if #(.NUM_REQ(N)) ifc ();

  lcd_write_arbiter #(
    .NUM_REQ  (N),
    .LINE_LEN (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .lcd_if  (ifc)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int model_last;

  logic       line_a [N];
  logic [3:0] col_a  [N];
  logic [4:0] len_a  [N];
  logic [7:0] msg    [N][16];

  // Requesters present the character for whatever index is asked.
  always_comb begin
    ifc.char_in = '0;
    for (int i = 0; i < N; i++) ifc.char_in[8*i +: 8] = msg[i][ifc.char_idx];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int eff_model(input int len, input int col);
    int sat, room;
    sat  = (len > 16) ? 16 : len;
    room = 16 - col;
    return (sat < room) ? sat : room;
  endfunction

  function automatic int predict(input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(model_last + k) % N]) return (model_last + k) % N;
    end
    return -1;
  endfunction

  task automatic drive_fields();
    for (int i = 0; i < N; i++) begin
      ifc.req_line[i]       = line_a[i];
      ifc.req_col[4*i +: 4] = col_a[i];
      ifc.req_len[5*i +: 5] = len_a[i];
    end
  endtask

  task automatic rand_fields(input int i);
    line_a[i] = 1'($urandom_range(1));
    col_a[i]  = 4'($urandom_range(15));
    len_a[i]  = 5'($urandom_range(31));
    for (int k = 0; k < 16; k++) msg[i][k] = 8'($urandom_range(126, 32));
  endtask

  // Follows one message from grant to done; called at a negedge.
  task automatic run_msg(input int g, input int rdy_pct, input bit timing);
    int         eff, exp_n, nbeat, cyc, guard;
    logic [8:0] exp_beat [17];
    logic [8:0] held;
    bit         stalled, rdy, fin;
    eff   = eff_model(int'(len_a[g]), int'(col_a[g]));
    exp_n = (eff == 0) ? 0 : eff + 1;
    exp_beat[0] = {1'b0, 8'h80 | (line_a[g] ? 8'h40 : 8'h00) | {4'h0, col_a[g]}};
    for (int k = 0; k < eff; k++) exp_beat[k+1] = {1'b1, msg[g][k]};
    guard = 0;
    @(negedge clk);
    while (ifc.gnt == '0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("grant", 32'(ifc.gnt), 32'(1 << g));
    if (ifc.gnt == '0) return;
    nbeat = 0; cyc = 0; stalled = 0; fin = 0; guard = 0;
    while (!fin && guard < 400) begin
      if (ifc.done != '0) begin
        chk("done", 32'(ifc.done), 32'(1 << g));
        chk("beats", nbeat, exp_n);
        if (timing) chk("cycles", cyc, exp_n);
        fin = 1;
      end else begin
        chk("gnt_held", 32'(ifc.gnt), 32'(1 << g));
        if (stalled) begin
          chk("stall_valid", 32'(ifc.bus_valid), 1);
          chk("stall_hold", {ifc.bus_rs, ifc.bus_data}, held);
        end
        rdy = ($urandom_range(99) < rdy_pct);
        ifc.bus_ready = rdy;
        stalled = 0;
        if (ifc.bus_valid) begin
          if (rdy) begin
            if (nbeat < exp_n)
              chk($sformatf("beat%0d", nbeat), {ifc.bus_rs, ifc.bus_data}, exp_beat[nbeat]);
            else
              chk("extra_beat", nbeat, exp_n);
            nbeat++;
          end else begin
            stalled = 1;
            held    = {ifc.bus_rs, ifc.bus_data};
          end
        end
        cyc++;
        @(negedge clk);
        guard++;
      end
    end
    if (!fin) chk("timeout", 0, 1);
    @(negedge clk);
    chk("gap", {ifc.gnt, ifc.done, ifc.bus_valid}, '0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"},   32'(ifc.gnt), 0);
    chk({tag, "_done"},  32'(ifc.done), 0);
    chk({tag, "_idx"},   32'(ifc.char_idx), 0);
    chk({tag, "_valid"}, 32'(ifc.bus_valid), 0);
    chk({tag, "_rs"},    32'(ifc.bus_rs), 0);
    chk({tag, "_data"},  32'(ifc.bus_data), 0);
  endtask

  initial begin
    int g, guard;
    logic [N-1:0] r;
    logic [7:0] p19 [4];
    reset_n       = 1'b0;
    ifc.req       = '0;
    ifc.bus_ready = 1'b0;
    for (int i = 0; i < N; i++) rand_fields(i);
    drive_fields();
    model_last = N - 1;
    #25;
    chk_reset_vals("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // All requesters high after reset: 0, 1, 2, 0.
    line_a[1] = 1'b0; col_a[1] = 4'd12; len_a[1] = 5'd10;
    drive_fields();
    ifc.req = 3'b111;
    for (int n = 0; n < 4; n++) begin
      g = predict(ifc.req);
      run_msg(g, 100, 1);
      model_last = g;
    end

    // Requester 1 writes "P1:9" at line 2, column 3.
    p19[0] = "P"; p19[1] = "1"; p19[2] = ":"; p19[3] = "9";
    line_a[1] = 1'b1; col_a[1] = 4'd3; len_a[1] = 5'd4;
    for (int k = 0; k < 4; k++) msg[1][k] = p19[k];
    drive_fields();
    ifc.req = 3'b010;
    g = predict(ifc.req);
    run_msg(g, 100, 1);
    model_last = g;

    // Zero-length request.
    len_a[2] = 5'd0;
    drive_fields();
    ifc.req = 3'b100;
    g = predict(ifc.req);
    run_msg(g, 100, 1);
    model_last = g;

    // Random requests, fields and bus back-pressure.
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < N; i++) rand_fields(i);
      drive_fields();
      r = 3'($urandom_range(7, 1));
      ifc.req = r;
      g = predict(r);
      if (n % 2 == 0) run_msg(g, 30, 0);
      else            run_msg(g, 100, 1);
      model_last = g;
    end

    // Reset during the second character beat aborts the message.
    line_a[2] = 1'b0; col_a[2] = 4'd0; len_a[2] = 5'd8;
    drive_fields();
    ifc.req       = 3'b100;
    ifc.bus_ready = 1'b1;
    guard = 0;
    while (!(ifc.bus_valid && ifc.bus_rs && ifc.char_idx == 4'd1) && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    chk("reach_beat2", 32'(guard < 30), 1);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("async");
    @(negedge clk);
    chk_reset_vals("held");
    ifc.req    = 3'b101;
    reset_n    = 1'b1;
    model_last = N - 1;
    g = predict(ifc.req);
    run_msg(g, 100, 1);
    model_last = g;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lcd_write_arbiter.md
# lcd_write_arbiter

Shares the single 16x2 character LCD between several display requesters, such as the game-status writer, the score writer and the dice-face writer. Each request describes one message region: line, start column and length. The block grants one requester at a time in round-robin order and serialises the message to the downstream byte-level LCD bus driver. That serialisation is one set-DDRAM-address command followed by the characters, using a valid/ready handshake. The bus driver owns enable-pulse generation and HD44780 command timing; this block only sequences and arbitrates.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- LINE_LEN, 16, characters per LCD line; max message length
- clk  in  1  system clock (50 MHz)
- reset_n  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  per-requester write request, level
- req_line  in  NUM_REQ  target line per requester (0: line 1, 1: line 2)
- req_col  in  NUM_REQ*4  start column per requester, flattened, requester i at [4i+3:4i]
- req_len  in  NUM_REQ*5  message length 0..16 per requester, flattened
- char_in  in  NUM_REQ*8  ASCII of character char_idx, per requester, combinational from char_idx
- gnt  out  NUM_REQ  one-hot grant, held for the whole message
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester
- char_idx  out  4  index of the character currently requested
- bus_valid  out  1  beat valid toward the LCD bus driver
- bus_rs  out  1  0: command, 1: data
- bus_data  out  8  command or character byte
- bus_ready  in  1  driver accepts the beat when bus_valid && bus_ready

## Operation
- States: IDLE, ADDR, CHAR, DONE. Encoding lives in the package.
- **IDLE**
  - When any req bit is high, pick the winner g by round-robin, searching from last_grant+1 upward with wrap.
  - Latch line, col and eff_len. eff_len = min(req_len[g], LINE_LEN − col); if req_len > 16, treat it as 16 before clamping.
  - Set gnt[g] and move to ADDR, or to DONE if eff_len == 0.
- **ADDR**
  - bus_valid=1, bus_rs=0, bus_data = 0x80 | (line ? 0x40 : 0x00) | col.
  - On accept: char_idx ← 0, move to CHAR.
- **CHAR**
  - bus_valid=1, bus_rs=1, bus_data = char_in[g] selected at the current char_idx.
  - On accept: if char_idx == eff_len−1, move to DONE; otherwise char_idx ← char_idx+1 and stay in CHAR.
- **DONE**
  - done[g]=1 for one cycle, last_grant ← g, gnt cleared, move to IDLE.
- Requester rules:
  - Hold line, col and len stable while gnt is high.
  - char_in must be valid combinationally for the presented char_idx.
- req deassertion while granted is ignored; the message completes. req still high after done counts as a new request and competes normally.
- req bits rising while another requester is granted wait; no pre-emption.
- A zero-length request is granted and completed with no bus traffic.

## Timing
- Reset values:
  - State IDLE.
  - gnt=0, done=0, char_idx=0, bus_valid=0, bus_rs=0, bus_data=0x00.
  - last_grant=NUM_REQ−1, so requester 0 wins first.
- Asynchronous reset mid-message aborts immediately. No done pulse is issued, and the partial LCD content is left as-is.
- State, gnt, done, char_idx and the latched fields are registered. bus_valid, bus_rs and bus_data are combinational from the registered state, the latched fields and char_in.
- Latency:
  - req sampled high in IDLE at edge n gives gnt and address beat valid from cycle n+1.
  - A message of L characters with bus_ready held high takes 1+1+L+1 cycles from the IDLE decision to the return to IDLE.
- Beats are back-to-back: bus_valid stays high across accepts within a message. Beat content changes only on the cycle after an accept.
- bus_valid=0 in IDLE and DONE, giving at least one idle bus cycle between messages.
- bus_ready low stalls indefinitely. bus_data and bus_rs stay stable while valid && !ready.

## Structure
- Shared package lcd_pkg:
  - state localparams.
  - LCD_CMD_SET_DDRAM=8'h80, LCD_LINE2_OFFSET=8'h40, LCD_LINE_LEN=16.
- Sub-module rr_arbiter (NUM_REQ parameter):
  - Inputs: req, last_grant.
  - Outputs: one-hot winner and any_req.
  - Purely combinational; the main FSM registers its output.

## Test plan
- req[1] with line=1, col=3, len=4, chars "P1:9", bus_ready=1 → beats (rs0,0xC3), (rs1,0x50), (rs1,0x31), (rs1,0x3A), (rs1,0x39), then done[1] for 1 cycle. Total 7 cycles.
- req=3'b111 held high after reset → grants in order 0, 1, 2, 0; each done precedes the next gnt; gnt is never multi-hot.
- line=0, col=12, len=10 → address 0x8C, exactly 4 data beats (char_idx 0..3), done.
- bus_ready toggled randomly, ~30% high → byte sequence identical to the ready-high case; bus_data is never changed while valid && !ready.
- len=0 request → gnt for 1 cycle, done pulse, zero bus_valid cycles.
- reset_n pulsed low during the second CHAR beat → all outputs return to reset values asynchronously; after release, req[0] is granted first with a fresh address beat.
